// File: rtl/ram_64x16.sv
// ram_64x16: single-port-per-cycle synchronous RAM (one write OR one read per
// clock) with a registered read port and a synchronous, active-high clear
// that wipes every stored word as well as the output register.
// The reset input keeps the name rst_n, but a 1 on it requests reset.
module ram_64x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64   // must equal 2**ADDR_W so every address maps to a word
) (
  input  logic              clk,
  input  logic              rst_n,    // synchronous, active-high clear
  input  logic              wr_rd,    // 1 = write cycle, 0 = read cycle
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;

  // Read-port next state: a read cycle loads the addressed word, a write cycle holds.
  always_comb begin
    // NOTE: assign the default first so every path drives data_out_d and no latch is inferred.
    data_out_d = data_out_q;
    if (!wr_rd) begin
      data_out_d = mem_q[rd_addr];
    end
  end

  // Storage: clear all words on reset, otherwise write on a write cycle only.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      // NOTE: the whole array is cleared here because reads after reset must return 0; this
      // forces the storage into flops rather than a RAM macro, which this small block accepts.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_rd) begin
      // NOTE: non-blocking so a same-edge read sees the pre-edge contents.
      mem_q[wr_addr] <= data_in;
    end
  end

  // Output register: reset has priority over the read/hold decision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_64x16.sv
// tb_ram_64x16: directed and randomized checks of ram_64x16 against a plain
// array model that applies the clear / write / read rules once per clock.
module tb_ram_64x16;

  logic        clk;
  logic        rst_n;
  logic        wr_rd;
  logic [15:0] data_in;
  logic [5:0]  wr_addr;
  logic [5:0]  rd_addr;
  logic [15:0] data_out;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] ref_mem [64];
  logic [15:0] ref_out;

  ram_64x16 #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_rd    (wr_rd),
    .data_in  (data_in),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the sequence is a few thousand cycles; this only trips on a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, update the model at the
  // rising edge, compare data_out 1 time unit later.
  task automatic step(input logic rst, input logic wr, input logic [15:0] din,
                      input logic [5:0] wa, input logic [5:0] ra, input string tag);
    @(negedge clk);
    rst_n   = rst;
    wr_rd   = wr;
    data_in = din;
    wr_addr = wa;
    rd_addr = ra;
    @(posedge clk);
    if (rst) begin
      foreach (ref_mem[i]) ref_mem[i] = 16'h0;
      ref_out = 16'h0;
    end else if (wr) begin
      ref_mem[wa] = din;
    end else begin
      ref_out = ref_mem[ra];
    end
    #1;
    check(tag, data_out, ref_out);
  endtask

  initial begin
    rst_n   = 1'b1;
    wr_rd   = 1'b0;
    data_in = '0;
    wr_addr = '0;
    rd_addr = '0;
    foreach (ref_mem[i]) ref_mem[i] = 16'hxxxx;
    ref_out = 16'hxxxx;

    // Reset, then reads of a cleared memory return 0
    step(1'b1, 1'b0, 16'h0, 6'd0, 6'd0, "reset");
    check("reset_out", data_out, 16'h0000);
    step(1'b0, 1'b0, 16'h0, 6'd0, 6'd0,  "rd0_after_reset");
    step(1'b0, 1'b0, 16'h0, 6'd0, 6'd8,  "rd8_after_reset");
    step(1'b0, 1'b0, 16'h0, 6'd0, 6'd63, "rd63_after_reset");
    check("rd63_zero", data_out, 16'h0000);

    // mem[i] = i, then strided reads wrapping from 56 back to 0
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 16'(i), 6'(i), 6'(63 - i), "fill_idx");
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        step(1'b0, 1'b0, 16'hFFFF, 6'(k), 6'(k * 8), "rd_stride");
        check("rd_stride_val", data_out, 16'(k * 8));
      end
    end
    step(1'b0, 1'b0, 16'h0, 6'd0, 6'd63, "rd_top");
    check("rd_top_val", data_out, 16'd63);

    // Output holds through a run of write cycles
    step(1'b0, 1'b0, 16'h0, 6'd0, 6'd24, "hold_load");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 16'($urandom), 6'($urandom), 6'd24, "hold_wr");
      check("hold_val", data_out, 16'd24);
    end

    // Write then immediate read; read cycle ignores data_in / wr_addr
    step(1'b0, 1'b1, 16'hBEEF, 6'd5, 6'd7, "beef_wr");
    step(1'b0, 1'b0, 16'h0,    6'd0, 6'd5, "beef_rd");
    check("beef_val", data_out, 16'hBEEF);
    step(1'b0, 1'b0, 16'h1234, 6'd5, 6'd5, "beef_rd_ignored_wr");
    step(1'b0, 1'b0, 16'h0,    6'd0, 6'd5, "beef_rd_again");
    check("beef_kept", data_out, 16'hBEEF);

    // Reset and write in the same cycle: the write is dropped
    step(1'b0, 1'b1, 16'h5555, 6'd3, 6'd0, "pre_wr3");
    step(1'b1, 1'b1, 16'h0007, 6'd3, 6'd0, "reset_with_wr");
    step(1'b0, 1'b0, 16'h0,    6'd0, 6'd3, "rd3_after_reset");
    check("rd3_zero", data_out, 16'h0000);

    // Randomized mixed traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 16'($urandom),
           6'($urandom), 6'($urandom), "rand_mix");
    end

    // Long write burst followed by long read burst
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 16'($urandom), 6'($urandom), 6'($urandom), "burst_wr");
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 16'($urandom), 6'($urandom), 6'($urandom), "burst_rd");

    // Fill with nonzero data, reset mid read burst, everything reads back 0
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 16'($urandom) | 16'h0001, 6'(i), 6'd0, "fill_rand");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 6'd0, 6'(i * 9), "pre_reset_rd");
    step(1'b1, 1'b0, 16'h0, 6'd0, 6'd10, "reset_mid_burst");
    check("reset_mid_burst_out", data_out, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, 16'hFFFF, 6'(i), 6'(i), "post_reset_rd");
      check("post_reset_zero", data_out, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_64x16.md
RAM_64X16 -- requirements
Module: ram_64x16

Interface
REQ-001: Parameter DATA_W, default 16, word width in bits.
REQ-002: Parameter ADDR_W, default 6, address width in bits.
REQ-003: Parameter DEPTH, default 64, number of words; SHALL equal 2**ADDR_W.
REQ-004: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005: rst_n  input  1  reset; synchronous, active-high (rst_n=1 resets on the next rising clk edge).
REQ-006: wr_rd  input  1  mode select; 1 = write cycle, 0 = read cycle.
REQ-007: data_in  input  DATA_W  write data.
REQ-008: wr_addr  input  ADDR_W  write address.
REQ-009: rd_addr  input  ADDR_W  read address.
REQ-010: data_out  output  DATA_W  registered read data.

Function
REQ-011: Storage SHALL be a DEPTH x DATA_W array, addressed 0..DEPTH-1, with no address translation.
REQ-012: Write cycle (rst_n=0, wr_rd=1): mem[wr_addr] SHALL take data_in at the clock edge; rd_addr SHALL be ignored.
REQ-013: Write cycle: data_out SHALL hold its previous value.
REQ-014: Read cycle (rst_n=0, wr_rd=0): data_out SHALL take mem[rd_addr] at the clock edge, giving 1-cycle latency; memory SHALL NOT change; wr_addr and data_in SHALL be ignored.
REQ-015: Read data SHALL be the content present before the edge. A read cycle immediately after a write to the same address SHALL return the newly written value.
REQ-016: All DEPTH addresses SHALL be usable, including 0 and DEPTH-1. Address arithmetic is external; the block SHALL accept any ADDR_W-bit value, e.g. 56 then 0.
REQ-017: Mode SHALL be able to change every cycle with no dead cycle. Long write bursts followed by long read bursts SHALL behave identically to alternating cycles.
REQ-018: No X SHALL propagate to data_out after the first reset, for any in-range address.

Reset
REQ-019: rst_n=1 at a rising edge SHALL clear every memory word to 0 and set data_out to 0, regardless of wr_rd.
REQ-020: Reset SHALL take precedence over write and read in the same cycle; no write SHALL occur during reset.
REQ-021: After rst_n returns to 0, the first edge SHALL perform a normal write or read.
REQ-022: Reset asserted mid-burst, in either mode, SHALL discard all stored data; later reads SHALL return 0 until the address is rewritten.

Verification
REQ-023: Reset, then read addresses 0, 8, 63 -> data_out = 0 one cycle after each.
REQ-024: Write mem[i]=i for i=0..63 (wr_rd=1), then read rd_addr = 0, 8, 16, ..., 56, then 0, 8, ... -> data_out = 0, 8, ..., 56, 0, 8, ... each one cycle after its address is applied.
REQ-025: Hold data_out at 24 (read addr 24), then do 10 write cycles -> data_out stays 24 throughout.
REQ-026: Write 0xBEEF to addr 5, next cycle read addr 5 -> data_out = 0xBEEF; with wr_rd=0, drive data_in=0x1234 and wr_addr=5, then read addr 5 -> still 0xBEEF.
REQ-027: Fill memory, assert rst_n=1 for 1 cycle during a read burst -> data_out = 0 at that edge, and every subsequent read returns 0.
REQ-028: Apply reset and a write in the same cycle (wr_rd=1, wr_addr=3, data_in=0x7) -> a later read of addr 3 returns 0.
